// File: rtl/fpga_slave_pkg.sv
// Shared constants for the FPGA slave FIFO: ARM command codes, FSM states
// and synchronizer depth.
package fpga_slave_pkg;

  localparam logic [3:0] CMD_NOP      = 4'b0000;
  localparam logic [3:0] CMD_READ_SER = 4'b0001;
  localparam logic [3:0] CMD_READ_PAR = 4'b1100;
  localparam logic [3:0] CMD_FLUSH    = 4'b1111;

  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StPar   = 2'd2
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; full/empty flags are registered from the
// next-state count so they change the cycle after a push or pop.
module sync_fifo #(
  parameter int unsigned DataW = 16,
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [DataW-1:0] wr_data_i,
  output logic [DataW-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [DataW-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             do_push, do_pop;

  // Pointer and count update; pointers wrap naturally at power-of-two depth
  always_comb begin
    do_pop   = pop_i & ~empty_q;
    do_push  = push_i & (~full_q | do_pop) & ~flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AddrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == CntW'(Depth));
    empty_d = (count_d == '0);
  end

  // Control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage; contents are meaningless after reset since pointers are cleared
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign count_o   = count_q;

endmodule

// File: rtl/fpga_slave_fifo.sv
// FPGA slave FIFO: buffers words from the datapath and serves them to the
// ARM host serially (paced by oversampled sclk) or as parallel slices.
// Optional trailing even-parity bit in serial mode: define FPGA_SLAVE_PARITY_EN.
module fpga_slave_fifo
  import fpga_slave_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CMD_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              in_enable,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CMD_W-1:0]  from_ARM,
  output logic              to_ARM,
  output logic              out_enable,
  output logic [OUT_W-1:0]  out_data,
  output logic              dirty,
  output logic              full,
  output logic              overflow
);

  localparam int unsigned NSlices = DATA_W / OUT_W;
  localparam int unsigned SliceW  = $clog2(NSlices + 1);
  localparam int unsigned CntW    = $clog2(DEPTH) + 1;
`ifdef FPGA_SLAVE_PARITY_EN
  localparam int unsigned NBits   = DATA_W + 1;
`else
  localparam int unsigned NBits   = DATA_W;
`endif
  localparam int unsigned BitW    = $clog2(NBits + 1);

  logic [SYNC_STAGES-1:0]            sclk_sync_q, sclk_sync_d;
  logic                              sclk_prev_q, sclk_prev_d;
  logic [SYNC_STAGES-1:0][CMD_W-1:0] cmd_sync_q, cmd_sync_d;
  state_e                            state_q, state_d;
  logic [NBits-1:0]                  shreg_q, shreg_d;
  logic [BitW-1:0]                   bit_cnt_q, bit_cnt_d;
  logic [SliceW-1:0]                 slice_cnt_q, slice_cnt_d;
  logic [OUT_W-1:0]                  out_data_q, out_data_d;
  logic                              overflow_q, overflow_d;

  logic              sclk_rise;
  logic [CMD_W-1:0]  cmd;
  logic              push, pop, flush, room;
  logic [DATA_W-1:0] head;
  logic              fifo_full, fifo_empty;
  logic [CntW-1:0]   fifo_count;

  sync_fifo #(
    .DataW (DATA_W),
    .Depth (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush),
    .push_i    (push),
    .pop_i     (pop),
    .wr_data_i (in_data),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign cmd       = cmd_sync_q[SYNC_STAGES-1];

  // Synchronizer shift, edge register, write acceptance and sticky overflow
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cmd_sync_d  = {cmd_sync_q[SYNC_STAGES-2:0], from_ARM};
    sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
    // A pop in the same cycle frees a slot for the incoming word
    room        = (fifo_count != CntW'(DEPTH));
    push        = in_enable & (room | pop);
    overflow_d  = flush ? 1'b0 : (overflow_q | (in_enable & ~room & ~pop));
  end

  // State register and datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cmd_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      state_q     <= StIdle;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      slice_cnt_q <= '0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cmd_sync_q  <= cmd_sync_d;
      sclk_prev_q <= sclk_prev_d;
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      slice_cnt_q <= slice_cnt_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  // Next-state: command decode in idle, bit pacing in shift, slice count in par
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    slice_cnt_d = slice_cnt_q;
    pop         = 1'b0;
    flush       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sclk_rise) begin
          if (cmd == CMD_W'(CMD_FLUSH)) begin
            flush = 1'b1;
          end else if (cmd == CMD_W'(CMD_READ_SER) && !fifo_empty) begin
            state_d   = StShift;
            bit_cnt_d = '0;
`ifdef FPGA_SLAVE_PARITY_EN
            shreg_d   = {head, ^head};
`else
            shreg_d   = head;
`endif
          end else if (cmd == CMD_W'(CMD_READ_PAR) && !fifo_empty) begin
            state_d     = StPar;
            slice_cnt_d = '0;
          end
        end
      end
      StShift: begin
        if (sclk_rise) begin
          if (cmd == CMD_W'(CMD_FLUSH)) begin
            flush   = 1'b1;
            state_d = StIdle;
          end else if (bit_cnt_q == BitW'(NBits - 1)) begin
            pop     = 1'b1;
            state_d = StIdle;
          end else begin
            shreg_d   = {shreg_q[NBits-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
      StPar: begin
        if (sclk_rise && cmd == CMD_W'(CMD_FLUSH)) begin
          flush   = 1'b1;
          state_d = StIdle;
        end else if (slice_cnt_q == SliceW'(NSlices - 1)) begin
          pop     = 1'b1;
          state_d = StIdle;
        end else begin
          slice_cnt_d = slice_cnt_q + SliceW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: decoded from state so reset clears them immediately
  always_comb begin
    to_ARM     = (state_q == StShift) & shreg_q[NBits-1];
    out_enable = (state_q == StPar);
    out_data   = out_enable ? head[OUT_W*32'(slice_cnt_q) +: OUT_W] : out_data_q;
    out_data_d = out_data;
    dirty      = ~fifo_empty;
    full       = fifo_full;
    overflow   = overflow_q;
  end

endmodule

// File: tb/tb_fpga_slave_fifo.sv
// Directed bench for fpga_slave_fifo; parity checks under FPGA_SLAVE_PARITY_EN.
module tb_fpga_slave_fifo;

`ifdef FPGA_SLAVE_PARITY_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif

  logic        clk = 1'b0;
  logic        rst, sclk, in_enable;
  logic [15:0] in_data;
  logic [3:0]  from_ARM;
  logic        to_ARM, out_enable, dirty, full, overflow;
  logic [7:0]  out_data;

  int tests = 0;
  int fails = 0;

  logic [7:0] par_log [64];
  int         par_total = 0;

  fpga_slave_fifo #(
    .DATA_W (16),
    .OUT_W  (8),
    .DEPTH  (4),
    .CMD_W  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .in_enable  (in_enable),
    .in_data    (in_data),
    .from_ARM   (from_ARM),
    .to_ARM     (to_ARM),
    .out_enable (out_enable),
    .out_data   (out_data),
    .dirty      (dirty),
    .full       (full),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Log every parallel slice
  always @(negedge clk) begin
    if (out_enable === 1'b1) begin
      if (par_total < 64) par_log[par_total] = out_data;
      par_total = par_total + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [3:0] c);
    from_ARM = c;
    tick(2);
    sclk = 1'b1;
    tick(5);
    sclk = 1'b0;
    tick(5);
  endtask

  task automatic write_word(input logic [15:0] w);
    in_enable = 1'b1;
    in_data   = w;
    tick(1);
    in_enable = 1'b0;
  endtask

  task automatic read_ser(output logic [NB-1:0] w);
    w = '0;
    send_cmd(4'b0001);
    w[NB-1] = to_ARM;
    for (int i = NB - 2; i >= 0; i--) begin
      send_cmd(4'b0000);
      w[i] = to_ARM;
    end
    send_cmd(4'b0000);
  endtask

  task automatic test_reset();
    tests++;
    if ({to_ARM, out_enable, out_data, dirty, full, overflow} !== 13'h0) begin
      $display("FAIL reset_in: got %h expected 0",
               {to_ARM, out_enable, out_data, dirty, full, overflow});
      fails++;
    end
    rst = 1'b0;
    tick(3);
    tests++;
    if ({to_ARM, out_enable, out_data, dirty, full, overflow} !== 13'h0) begin
      $display("FAIL reset_out: got %h expected 0",
               {to_ARM, out_enable, out_data, dirty, full, overflow});
      fails++;
    end
  endtask

  task automatic test_serial();
    logic [15:0] exp_w;
    exp_w = 16'h00F3;
    write_word(exp_w);
    tests++;
    if (dirty !== 1'b1) begin
      $display("FAIL ser_dirty: got %b expected 1", dirty);
      fails++;
    end
    send_cmd(4'b0001);
    for (int i = 15; i >= 0; i--) begin
      tests++;
      if (to_ARM !== exp_w[i]) begin
        $display("FAIL ser_bit%0d: got %b expected %b", i, to_ARM, exp_w[i]);
        fails++;
      end
      if (i > 0) send_cmd(4'b0000);
    end
`ifdef FPGA_SLAVE_PARITY_EN
    send_cmd(4'b0000);
`endif
    send_cmd(4'b0000);
    tests++;
    if ({dirty, to_ARM} !== 2'b00) begin
      $display("FAIL ser_after_pop: got %b expected 00", {dirty, to_ARM});
      fails++;
    end
  endtask

  task automatic test_parallel();
    int start;
    write_word(16'h00F3);
    start = par_total;
    send_cmd(4'b1100);
    tests++;
    if (par_total - start !== 2) begin
      $display("FAIL par_count: got %0d expected 2", par_total - start);
      fails++;
    end else begin
      tests++;
      if (par_log[start] !== 8'hF3) begin
        $display("FAIL par_slice0: got %h expected f3", par_log[start]);
        fails++;
      end
      tests++;
      if (par_log[start+1] !== 8'h00) begin
        $display("FAIL par_slice1: got %h expected 00", par_log[start+1]);
        fails++;
      end
    end
    tests++;
    if ({out_enable, out_data, dirty} !== 10'h0) begin
      $display("FAIL par_after: got %h expected 0", {out_enable, out_data, dirty});
      fails++;
    end
  endtask

  task automatic test_overflow();
    logic [NB-1:0] w;
    for (int i = 1; i <= 5; i++) begin
      in_enable = 1'b1;
      in_data   = 16'(i);
      tick(1);
    end
    in_enable = 1'b0;
    tick(1);
    tests++;
    if ({full, overflow} !== 2'b11) begin
      $display("FAIL ovf_flags: got %b expected 11", {full, overflow});
      fails++;
    end
    for (int i = 1; i <= 4; i++) begin
      read_ser(w);
      tests++;
      if (w[NB-1 -: 16] !== 16'(i)) begin
        $display("FAIL ovf_read%0d: got %h expected %h", i, w[NB-1 -: 16], 16'(i));
        fails++;
      end
    end
    tests++;
    if ({dirty, full, overflow} !== 3'b001) begin
      $display("FAIL ovf_drained: got %b expected 001", {dirty, full, overflow});
      fails++;
    end
    send_cmd(4'b1111);
    tests++;
    if (overflow !== 1'b0) begin
      $display("FAIL ovf_flush: got %b expected 0", overflow);
      fails++;
    end
  endtask

  task automatic test_simultaneous();
    logic [NB-1:0] w;
    int            seen;
    bit            hit;
    logic [15:0]   exp_w [4];
    for (int i = 0; i < 4; i++) write_word(16'hA1 + 16'(i));
    tests++;
    if ({full, overflow} !== 2'b10) begin
      $display("FAIL sim_prefill: got %b expected 10", {full, overflow});
      fails++;
    end
    seen = 0;
    hit  = 1'b0;
    from_ARM = 4'b1100;
    tick(2);
    sclk = 1'b1;
    for (int c = 0; c < 40 && !hit; c++) begin
      if (out_enable === 1'b1) seen++;
      if (seen == 2) begin
        // Push lands on the same edge as the last-slice pop
        in_enable = 1'b1;
        in_data   = 16'h00A5;
        tick(1);
        in_enable = 1'b0;
        hit = 1'b1;
      end else begin
        tick(1);
      end
    end
    tick(3);
    sclk = 1'b0;
    tick(5);
    tests++;
    if (hit !== 1'b1) begin
      $display("FAIL sim_timeout: got %0d slices expected 2", seen);
      fails++;
    end
    tests++;
    if ({full, overflow} !== 2'b10) begin
      $display("FAIL sim_flags: got %b expected 10", {full, overflow});
      fails++;
    end
    exp_w[0] = 16'h00A2;
    exp_w[1] = 16'h00A3;
    exp_w[2] = 16'h00A4;
    exp_w[3] = 16'h00A5;
    for (int i = 0; i < 4; i++) begin
      read_ser(w);
      tests++;
      if (w[NB-1 -: 16] !== exp_w[i]) begin
        $display("FAIL sim_read%0d: got %h expected %h", i, w[NB-1 -: 16], exp_w[i]);
        fails++;
      end
    end
  endtask

`ifdef FPGA_SLAVE_PARITY_EN
  task automatic test_parity();
    logic [NB-1:0] w;
    write_word(16'h00F3);
    write_word(16'h0001);
    read_ser(w);
    tests++;
    if (w !== 17'h001E6) begin
      $display("FAIL parity_f3: got %h expected 001e6", w);
      fails++;
    end
    read_ser(w);
    tests++;
    if (w !== 17'h00003) begin
      $display("FAIL parity_01: got %h expected 00003", w);
      fails++;
    end
  endtask
`endif

  task automatic test_reset_mid_shift();
    write_word(16'h8001);
    write_word(16'h1234);
    send_cmd(4'b0001);
    tests++;
    if (to_ARM !== 1'b1) begin
      $display("FAIL rst_pre_msb: got %b expected 1", to_ARM);
      fails++;
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({to_ARM, out_enable, out_data, dirty, full, overflow} !== 13'h0) begin
      $display("FAIL rst_mid: got %h expected 0",
               {to_ARM, out_enable, out_data, dirty, full, overflow});
      fails++;
    end
    tick(2);
    rst = 1'b0;
    tick(3);
    tests++;
    if ({dirty, to_ARM} !== 2'b00) begin
      $display("FAIL rst_release: got %b expected 00", {dirty, to_ARM});
      fails++;
    end
  endtask

  initial begin
    rst       = 1'b1;
    sclk      = 1'b0;
    in_enable = 1'b0;
    in_data   = '0;
    from_ARM  = 4'b0000;
    tick(3);
    test_reset();
    test_serial();
    test_parallel();
    test_overflow();
    test_simultaneous();
`ifdef FPGA_SLAVE_PARITY_EN
    test_parity();
`endif
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpga_slave_fifo.md
Name: fpga_slave_fifo

Overview:
- Parametrised successor to the single-word FPGA slave receiver.
- Buffers DEPTH words of DATA_W bits written by the FPGA datapath.
- Serves them to the ARM host either bit-serially on to_ARM, paced by the ARM-driven sclk, or as OUT_W-bit parallel slices on out_data.
- Sits between the local capture logic and the ARM command interface; sclk is oversampled in the clk domain (single clock).

Parameters:
- DATA_W, 16, width of buffered word; must be a multiple of OUT_W.
- OUT_W, 8, parallel output slice width.
- DEPTH, 4, FIFO depth in words; power of two, >= 2.
- CMD_W, 4, width of from_ARM command nibble.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- sclk  input  1  ARM serial clock, asynchronous to clk; needs >= 4 clk periods per sclk phase.
- in_enable  input  1  write strobe; one word is written per cycle it is high.
- in_data  input  DATA_W  word to buffer.
- from_ARM  input  CMD_W  ARM command; stable >= 3 clk around each sclk rising edge.
- to_ARM  output  1  serial data to ARM, MSB first.
- out_enable  output  1  qualifies out_data, one pulse per slice.
- out_data  output  OUT_W  parallel slice.
- dirty  output  1  FIFO non-empty.
- full  output  1  FIFO holds DEPTH words.
- overflow  output  1  sticky: a write was dropped.

Behaviour:
- Reset values: to_ARM=0, out_enable=0, out_data=0, dirty=0, full=0, overflow=0; FIFO empty; FSM=IDLE. Reset mid-transfer aborts the transfer and discards FIFO contents.
- sclk and from_ARM pass through a 2-flop synchronizer plus edge register. A sclk rising edge is detected 3 clk after the pin edge; from_ARM is sampled on that same detect cycle.
- Write: if in_enable and (not full, or a pop occurs the same cycle), push in_data. If full and there is no pop, drop the word and set overflow.
- Simultaneous push and pop leaves the count unchanged. dirty and full are registered from the count and update the cycle after the push/pop.
- Commands are decoded only in IDLE, on a detected sclk rise:
  - 0000 NOP.
  - 0001 READ_SER.
  - 1100 READ_PAR.
  - 1111 FLUSH.
  - All other codes are ignored.
- FLUSH: empties the FIFO and clears overflow. It is also honoured in SHIFT and PAR: it aborts without a pop and returns to IDLE with to_ARM=0 and out_enable=0.
- READ_SER or READ_PAR with the FIFO empty: ignored, no state change.
- FSM states: IDLE, SHIFT, PAR.
- IDLE->SHIFT on READ_SER with dirty:
  - Head word is latched into a shift register.
  - to_ARM = bit DATA_W-1 from the next clk.
  - Each later detected sclk rise advances one bit.
  - After the sclk rise that follows bit 0, the word is popped, to_ARM returns to 0, and the FSM goes to IDLE.
- IDLE->PAR on READ_PAR with dirty:
  - For DATA_W/OUT_W consecutive clk cycles, out_enable=1 and out_data = slice k, k=0 first (least significant slice first).
  - Pop on the last slice cycle, then IDLE.
  - out_data holds its last value when out_enable=0.
- Pointer wrap: read and write pointers wrap modulo DEPTH. The count field is log2(DEPTH)+1 bits wide.

Optional Feature:
- Macro: FPGA_SLAVE_PARITY_EN.
- When defined: SHIFT emits one extra bit after bit 0, the even parity (XOR) of the word. The pop happens one sclk rise later.
- When undefined: exactly DATA_W bits are emitted and there is no parity logic.

Decomposition:
- Shared package fpga_slave_pkg holds:
  - Command localparams CMD_NOP, CMD_READ_SER, CMD_READ_PAR, CMD_FLUSH.
  - FSM state encoding.
  - Synchronizer depth constant SYNC_STAGES=2.
- One sub-module is natural: sync_fifo (DEPTH x DATA_W) with push, pop, full, empty, count and flush.

Test Plan:
- Reset: assert rst mid-SHIFT -> all outputs 0 within the same cycle; dirty=0 after release.
- Serial: write 0x00F3, then READ_SER -> to_ARM sequence 0000000011110011 over 16 sclk rises; dirty falls after the pop.
- Parallel: write 0x00F3, then READ_PAR -> out_enable high for 2 clk with out_data 0xF3 then 0x00; FIFO empty afterwards.
- Overflow: 5 writes 0x0001..0x0005 with DEPTH=4 -> full=1, overflow=1; serial reads return 1,2,3,4; FLUSH clears overflow.
- Simultaneous: FIFO full while a PAR pop coincides with in_enable -> word accepted, overflow stays 0, count stays 4.
- Parity (macro defined): word 0x00F3 -> 17th bit = 0; word 0x0001 -> 17th bit = 1.
